// File: rtl/icsp_program_loader.sv
// icsp_program_loader: serial ICSP write side of the 12-bit flash program memory.
// Receives LSB-first framed commands on icsp_clk/icsp_data and drives word writes,
// address loads and bulk erase. cpu_hold keeps the CPU parked while programming.
// Optional feature macro: ICSP_READBACK_EN (adds READ_DATA cmd, mem_rdata, icsp_dout).
module icsp_program_loader #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 12,
  parameter int MEM_DEPTH    = 1024,
  parameter int WRITE_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic              prog_en,
  input  logic              icsp_clk,
  input  logic              icsp_data,
`ifdef ICSP_READBACK_EN
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              icsp_dout,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              error
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  localparam logic [3:0] CMD_LOAD_ADDR  = 4'h0;
  localparam logic [3:0] CMD_LOAD_DATA  = 4'h2;
  localparam logic [3:0] CMD_INC_ADDR   = 4'h6;
  localparam logic [3:0] CMD_BULK_ERASE = 4'h9;
`ifdef ICSP_READBACK_EN
  localparam logic [3:0] CMD_READ_DATA  = 4'h4;
`endif

  typedef enum logic [2:0] {
    S_OFF, S_CMD, S_DATA, S_WRITE, S_ERASE
`ifdef ICSP_READBACK_EN
    , S_READ
`endif
  } state_t;

  // {prog_en, icsp_clk, icsp_data} travel together so data stays aligned to its clock edge
  logic [SYNC_STAGES-1:0][2:0] syn;
  logic [1:0]                  prev;   // {prog_en, icsp_clk} one cycle after the last sync stage
  logic                        pe_s, ck_s, dt_s, pe_rise, ck_rise;

  state_t            state_q, state_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [DATA_W-1:0] sr_q, sr_n, sr_shift;
  logic [BW-1:0]     bcnt_q, bcnt_n;
  logic [CW-1:0]     wcnt_q, wcnt_n;
  logic [3:0]        cmd_q, cmd_n, cmd_in;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              err_q, err_n;
`ifdef ICSP_READBACK_EN
  logic              dout_q, dout_n;
  logic              rlat_q, rlat_n;
`endif

  // input synchronizers plus edge-detect history
  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      syn  <= '0;
      prev <= '0;
    end else begin
      syn[0] <= {prog_en, icsp_clk, icsp_data};
      for (int i = 1; i < SYNC_STAGES; i++) syn[i] <= syn[i-1];
      prev <= syn[SYNC_STAGES-1][2:1];
    end
  end

  assign pe_s    = syn[SYNC_STAGES-1][2];
  assign ck_s    = syn[SYNC_STAGES-1][1];
  assign dt_s    = syn[SYNC_STAGES-1][0];
  assign pe_rise = pe_s & ~prev[1];
  assign ck_rise = ck_s & ~prev[0];

  // state and datapath registers
  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_OFF;
      addr_q  <= '0;
      sr_q    <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      cmd_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef ICSP_READBACK_EN
      dout_q  <= 1'b0;
      rlat_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      sr_q    <= sr_n;
      bcnt_q  <= bcnt_n;
      wcnt_q  <= wcnt_n;
      cmd_q   <= cmd_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
`ifdef ICSP_READBACK_EN
      dout_q  <= dout_n;
      rlat_q  <= rlat_n;
`endif
    end
  end

  // shift register is filled from the top, so after N bits the frame sits in the top N bits
  assign sr_shift = {dt_s, sr_q[DATA_W-1:1]};
  assign cmd_in   = sr_shift[DATA_W-1 -: 4];

  // next-state and datapath update
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    sr_n    = sr_q;
    bcnt_n  = bcnt_q;
    wcnt_n  = wcnt_q;
    cmd_n   = cmd_q;
    wdata_n = wdata_q;
    err_n   = err_q;
`ifdef ICSP_READBACK_EN
    dout_n  = dout_q;
    rlat_n  = rlat_q;
`endif
    case (state_q)
      S_OFF: begin
        // an icsp edge coinciding with the rise is dropped simply by not shifting here
        if (pe_rise) begin
          state_n = S_CMD;
          addr_n  = '0;
          err_n   = 1'b0;
          bcnt_n  = '0;
        end
      end
      S_CMD: begin
        if (ck_rise) begin
          sr_n   = sr_shift;
          bcnt_n = bcnt_q + BW'(1);
          if (bcnt_q == BW'(3)) begin
            bcnt_n = '0;
            cmd_n  = cmd_in;
            case (cmd_in)
              CMD_LOAD_ADDR, CMD_LOAD_DATA: state_n = S_DATA;
              CMD_INC_ADDR:                 addr_n  = addr_q + AW'(1);
              CMD_BULK_ERASE: begin
                state_n = S_ERASE;
                addr_n  = '0;
                wcnt_n  = '0;
                wdata_n = '1;
              end
`ifdef ICSP_READBACK_EN
              CMD_READ_DATA: begin
                state_n = S_READ;
                rlat_n  = 1'b0;
              end
`endif
              default:                      err_n   = 1'b1;
            endcase
          end
        end
      end
      S_DATA: begin
        if (ck_rise) begin
          sr_n   = sr_shift;
          bcnt_n = bcnt_q + BW'(1);
          if (bcnt_q == BW'(DATA_W-1)) begin
            bcnt_n = '0;
            if (cmd_q == CMD_LOAD_ADDR) begin
              addr_n  = sr_shift[AW-1:0];
              state_n = S_CMD;
            end else begin
              wdata_n = sr_shift;
              wcnt_n  = '0;
              state_n = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (ck_rise) err_n = 1'b1;
        if (wcnt_q == CW'(WRITE_CYCLES-1)) state_n = S_CMD;
        else                               wcnt_n  = wcnt_q + CW'(1);
      end
      S_ERASE: begin
        // addr_q doubles as the erase pointer; it wraps back to 0 on the last word
        if (ck_rise) err_n = 1'b1;
        if (wcnt_q == CW'(WRITE_CYCLES-1)) begin
          wcnt_n = '0;
          addr_n = addr_q + AW'(1);
          if (addr_q == AW'(MEM_DEPTH-1)) state_n = S_CMD;
        end else begin
          wcnt_n = wcnt_q + CW'(1);
        end
      end
`ifdef ICSP_READBACK_EN
      S_READ: begin
        // bit 0 is presented right after the latch; each edge advances to the next bit
        if (!rlat_q) begin
          sr_n   = mem_rdata;
          dout_n = mem_rdata[0];
          rlat_n = 1'b1;
          bcnt_n = '0;
        end else if (ck_rise) begin
          if (bcnt_q == BW'(DATA_W-1)) begin
            state_n = S_CMD;
            dout_n  = 1'b0;
            bcnt_n  = '0;
          end else begin
            sr_n   = sr_q >> 1;
            dout_n = sr_q[1];
            bcnt_n = bcnt_q + BW'(1);
          end
        end
      end
`endif
      default: state_n = S_OFF;
    endcase
    // leaving programming mode wins over everything; error is kept
    if (state_q != S_OFF && !pe_s) begin
      state_n = S_OFF;
      bcnt_n  = '0;
`ifdef ICSP_READBACK_EN
      dout_n  = 1'b0;
`endif
    end
  end

  assign busy      = (state_q == S_WRITE) || (state_q == S_ERASE);
  assign mem_we    = busy && (wcnt_q == '0);
  assign cpu_hold  = (state_q != S_OFF);
  assign mem_addr  = ADDR_W'(addr_q);
  assign mem_wdata = wdata_q;
  assign error     = err_q;
`ifdef ICSP_READBACK_EN
  assign icsp_dout = dout_q;
`endif
endmodule
